// File: rtl/bnn_bin_pkg.sv
// Shared types and constants for the BNN input binarization controller.
package bnn_bin_pkg;

  localparam int PIX_BITS   = 8;
  localparam int LANE_BITS  = 256;
  localparam int PIX_OFFSET = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATHER,
    ST_CONVERT,
    ST_EMIT,
    ST_DONE
  } bin_ctrl_state_e;

  typedef logic signed [PIX_BITS-1:0] pix_t;
  typedef logic [LANE_BITS-1:0]       lane_t;

endpackage

// File: rtl/binarization_input.sv
// Combinational thermometer coder: each signed pixel p lights the low p+PIX_OFFSET bits of its lane.
module binarization_input
  import bnn_bin_pkg::*;
#(
  parameter int KERNEL_SIZE = 9,
  parameter int BIT_WIDTH   = 8,
  parameter int CHANNEL_CNT = 256
) (
  input  logic [KERNEL_SIZE*BIT_WIDTH-1:0]   win,
  output logic [KERNEL_SIZE*CHANNEL_CNT-1:0] bin
);

  logic signed [BIT_WIDTH-1:0] p;
  int                          level;

  always_comb begin
    bin   = '0;
    p     = '0;
    level = 0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      p     = win[i*BIT_WIDTH +: BIT_WIDTH];
      level = int'(p) + PIX_OFFSET;
      for (int j = 0; j < CHANNEL_CNT; j++) begin
        bin[i*CHANNEL_CNT + j] = (j < level);
      end
    end
  end

endmodule

// File: rtl/binarization_input_ctrl.sv
// Gathers KERNEL_SIZE pixels into a window, registers its thermometer code and
// presents it downstream with valid/ready, counting kernel groups per frame.
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 9
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif
`ifndef CHANNEL_CNT
`define CHANNEL_CNT 256
`endif

module binarization_input_ctrl
  import bnn_bin_pkg::*;
#(
  parameter int KERNEL_SIZE = `KERNEL_SIZE,
  parameter int BIT_WIDTH   = `BIT_WIDTH,
  parameter int CHANNEL_CNT = `CHANNEL_CNT,
  parameter int GRP_W       = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [GRP_W-1:0]                   cfg_groups,
  output logic                               busy,
  output logic                               done,
  input  logic                               pix_valid,
  output logic                               pix_ready,
  input  logic [BIT_WIDTH-1:0]               pix_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [KERNEL_SIZE*CHANNEL_CNT-1:0] out_data,
  output logic                               out_last,
  output logic [GRP_W-1:0]                   grp_idx
);

  localparam int CW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int DW = KERNEL_SIZE*CHANNEL_CNT;

  // Handshakes: a beat transfers on the rising edge where valid && ready.
  // pix_ready and out_valid are decoded from state only; out_valid holds
  // with out_data stable until out_ready is seen.
  bin_ctrl_state_e             state, state_next;
  logic [CW-1:0]               pix_cnt;
  logic [BIT_WIDTH-1:0]        win [KERNEL_SIZE];
  logic [KERNEL_SIZE*BIT_WIDTH-1:0] win_flat;
  logic [GRP_W-1:0]            groups;
  logic [DW-1:0]               bin;
  logic                        pix_fire, last_pix, out_fire, last_grp;

  assign pix_fire = pix_valid && pix_ready;
  assign last_pix = (pix_cnt == CW'(KERNEL_SIZE-1));
  assign out_fire = out_valid && out_ready;
  assign last_grp = (grp_idx == groups - GRP_W'(1));

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) win_flat[i*BIT_WIDTH +: BIT_WIDTH] = win[i];
  end

  binarization_input #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .BIT_WIDTH   (BIT_WIDTH),
    .CHANNEL_CNT (CHANNEL_CNT)
  ) u_bin (
    .win (win_flat),
    .bin (bin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = (cfg_groups == '0) ? ST_DONE : ST_GATHER;
      ST_GATHER:  if (pix_fire && last_pix) state_next = ST_CONVERT;
      ST_CONVERT: state_next = ST_EMIT;
      ST_EMIT:    if (out_fire) state_next = last_grp ? ST_DONE : ST_GATHER;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    pix_ready = (state == ST_GATHER);
    out_valid = (state == ST_EMIT);
    out_last  = (state == ST_EMIT) && last_grp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt  <= '0;
      grp_idx  <= '0;
      groups   <= '0;
      out_data <= '0;
      for (int i = 0; i < KERNEL_SIZE; i++) win[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          groups  <= cfg_groups;
          grp_idx <= '0;
          pix_cnt <= '0;
        end
        ST_GATHER: if (pix_fire) begin
          win[pix_cnt] <= pix_data;
          pix_cnt      <= last_pix ? '0 : pix_cnt + CW'(1);
        end
        ST_CONVERT: out_data <= bin;
        ST_EMIT:    if (out_fire && !last_grp) grp_idx <= grp_idx + GRP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binarization_input_ctrl.sv
// Directed bench for binarization_input_ctrl: framing, latency, stalls, extremes and reset.
module tb_binarization_input_ctrl;

  localparam int KS = 9;
  localparam int BW = 8;
  localparam int CC = 256;
  localparam int GW = 16;
  localparam int DW = KS*CC;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [GW-1:0] cfg_groups;
  logic          busy, done;
  logic          pix_valid, pix_ready;
  logic [BW-1:0] pix_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic [GW-1:0] grp_idx;

  int total = 0;
  int bad = 0;
  int accepted = 0;
  int win_p [KS];
  logic [DW-1:0] snap;

  binarization_input_ctrl #(
    .KERNEL_SIZE (KS), .BIT_WIDTH (BW), .CHANNEL_CNT (CC), .GRP_W (GW)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .cfg_groups (cfg_groups),
    .busy (busy), .done (done), .pix_valid (pix_valid), .pix_ready (pix_ready),
    .pix_data (pix_data), .out_valid (out_valid), .out_ready (out_ready),
    .out_data (out_data), .out_last (out_last), .grp_idx (grp_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && pix_valid && pix_ready) accepted++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data();
    logic [DW-1:0] v;
    logic [CC-1:0] one;
    one = 1;
    v = '0;
    for (int i = 0; i < KS; i++) v[i*CC +: CC] = (one << (win_p[i] + 128)) - one;
    return v;
  endfunction

  task automatic check_data(input string tag);
    logic [DW-1:0] e;
    int lane;
    e = exp_data();
    total++;
    assert (out_data === e) else begin
      bad++;
      lane = 0;
      for (int i = KS-1; i >= 0; i--) if (out_data[i*CC +: CC] !== e[i*CC +: CC]) lane = i;
      $error("FAIL %s lane=%0d observed_ones=%0d expected_ones=%0d", tag, lane,
             $countones(out_data[lane*CC +: CC]), $countones(e[lane*CC +: CC]));
    end
  endtask

  task automatic send_window(input bit gaps, input bit starts);
    int k = 0;
    int guard = 0;
    bit go;
    while (k < KS && guard < 200) begin
      pix_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      pix_data  = BW'(win_p[k]);
      start     = starts && ($urandom_range(0, 3) == 0);
      go        = pix_valid && pix_ready;
      tick();
      if (go) k++;
      guard++;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    if (k != KS) begin
      total++;
      bad++;
      $error("FAIL send_window_timeout sent=%0d required=%0d", k, KS);
    end
  endtask

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; cfg_groups = '0; pix_valid = 1'b0; pix_data = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_grp_idx", grp_idx, 0);
    check("rst_out_data_zero", (out_data == '0), 1);
    rst = 1'b0;
    tick();

    // single group, ramp pixels 0..8
    out_ready = 1'b1;
    for (int i = 0; i < KS; i++) win_p[i] = i;
    cfg_groups = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_pix_ready", pix_ready, 1);
    send_window(0, 0);
    check("t1_convert_no_valid", out_valid, 0);
    check("t1_convert_no_ready", pix_ready, 0);
    tick();
    check("t1_out_valid", out_valid, 1);
    check("t1_out_last", out_last, 1);
    check("t1_grp_idx", grp_idx, 0);
    check("t1_lane0_ones", $countones(out_data[0 +: CC]), 128);
    check("t1_lane8_ones", $countones(out_data[8*CC +: CC]), 136);
    check_data("t1_data");
    tick();
    check("t1_done", done, 1);
    check("t1_done_busy", busy, 1);
    check("t1_done_no_valid", out_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_done_cleared", done, 0);
    check("t1_idle_busy", busy, 0);
    tick();
    check("t1_start_in_done_ignored", busy, 0);

    // extremes
    for (int i = 0; i < KS; i++) win_p[i] = (i % 2 == 0) ? -128 : 127;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_window(0, 0);
    tick();
    check("t2_out_valid", out_valid, 1);
    check("t2_lane0_ones", $countones(out_data[0 +: CC]), 0);
    check("t2_lane1_ones", $countones(out_data[CC +: CC]), 255);
    check("t2_lane1_msb", out_data[2*CC-1], 0);
    check_data("t2_data");
    tick();
    check("t2_done", done, 1);
    tick();

    // three groups with a 5-cycle stall each
    out_ready = 1'b0;
    accepted = 0;
    cfg_groups = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < KS; i++) win_p[i] = g*20 - 60 + i*7;
      send_window(0, 0);
      tick();
      tick();
      check("t3_out_valid", out_valid, 1);
      check("t3_grp_idx", grp_idx, g);
      check("t3_out_last", out_last, (g == 2));
      check_data("t3_data");
      snap = exp_data();
      pix_valid = 1'b1;
      repeat (5) begin
        tick();
        check("t3_stall_valid", out_valid, 1);
        check("t3_stall_stable", (out_data === snap), 1);
        check("t3_stall_no_pix_ready", pix_ready, 0);
      end
      pix_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (g < 2) check("t3_next_gather", pix_ready, 1);
      else       check("t3_done", done, 1);
    end
    tick();
    check("t3_accepted", accepted, 27);
    check("t3_idle", busy, 0);

    // zero groups
    cfg_groups = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_done", done, 1);
    check("t4_no_pix_ready", pix_ready, 0);
    tick();
    check("t4_done_cleared", done, 0);
    check("t4_idle", busy, 0);
    check("t4_still_no_pix_ready", pix_ready, 0);

    // random pix_valid gaps, stray starts and a changed cfg_groups mid-frame
    out_ready = 1'b1;
    cfg_groups = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    cfg_groups = 16'd5;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < KS; i++) win_p[i] = int'($urandom_range(0, 255)) - 128;
      send_window(1, 1);
      w = 0;
      while (!out_valid && w < 5) begin
        tick();
        w++;
      end
      check("t5_latency", w, 1);
      check("t5_grp_idx", grp_idx, g);
      check("t5_out_last", out_last, (g == 1));
      check_data("t5_data");
      tick();
    end
    check("t5_done", done, 1);
    tick();
    check("t5_idle", busy, 0);

    // asynchronous reset after a partial window
    out_ready = 1'b1;
    cfg_groups = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_data = BW'(i + 40);
      tick();
    end
    pix_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_pix_ready", pix_ready, 0);
    check("t6_done", done, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_grp_idx", grp_idx, 0);
    check("t6_out_data_zero", (out_data == '0), 1);
    tick();
    rst = 1'b0;
    tick();
    check("t6_no_done_after_rst", done, 0);
    for (int i = 0; i < KS; i++) win_p[i] = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_window(0, 0);
    tick();
    check("t6_out_valid", out_valid, 1);
    for (int i = 0; i < KS; i++) check("t6_lane_ones", $countones(out_data[i*CC +: CC]), 133);
    tick();
    check("t6_done", done, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/binarization_input_ctrl.md
# binarization_input_ctrl

Sequencing controller for the input binarization stage of the BNN front end. It accepts a signed pixel stream one pixel per beat and gathers `KERNEL_SIZE` pixels into a kernel window. It drives the combinational `binarization_input` stage with that window and registers the thermometer-coded result. It presents the result downstream with a valid/ready handshake and counts kernel groups per frame under a start/done protocol.

## Interface
Parameters:
- `KERNEL_SIZE`, default `` `KERNEL_SIZE `` (9): pixels per kernel window.
- `BIT_WIDTH`, default `` `BIT_WIDTH `` (8): signed two's-complement pixel width.
- `CHANNEL_CNT`, default `` `CHANNEL_CNT `` (256): thermometer channels per pixel.
- `GRP_W`, default 16: width of the group count and group index.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle frame start; sampled only in IDLE.
- `cfg_groups` in GRP_W: kernel groups in the frame; latched on accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `pix_valid` in 1: input pixel valid.
- `pix_ready` out 1: input pixel accepted when valid&&ready.
- `pix_data` in BIT_WIDTH: signed pixel.
- `out_valid` out 1: binarized window valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out KERNEL_SIZE*CHANNEL_CNT: lane i is at bits [i*CHANNEL_CNT +: CHANNEL_CNT].
- `out_last` out 1: qualifies the final group of the frame.
- `grp_idx` out GRP_W: index of the group currently presented or gathered.

## Operation
- FSM states are IDLE, GATHER, CONVERT, EMIT and DONE.
- **IDLE:** On `start`, latch `cfg_groups` and clear `grp_idx`.
  - If `cfg_groups==0`, go to DONE.
  - Otherwise go to GATHER.
- **GATHER:** `pix_ready=1`.
  - Each accepted beat writes `pix_data` to `win[pix_cnt]` and increments `pix_cnt`.
  - The beat accepted at `pix_cnt==KERNEL_SIZE-1` clears `pix_cnt` and moves to CONVERT.
- **CONVERT:** `pix_ready=0`. Register the binarizer output of `win` into `out_data`, then go to EMIT.
- **EMIT:** `out_valid=1`. `out_last=(grp_idx==groups-1)`.
  - On `out_ready` with last: go to DONE.
  - On `out_ready` otherwise: increment `grp_idx` and go to GATHER.
  - `out_data` is held stable while stalled.
- **DONE:** `done=1` for one cycle, then return to IDLE.
- **Binarization rule:** for pixel value p in [-128,127], lane bits [p+127:0] are 1 and all other bits are 0. Ones count is p+128, so p=-128 gives all zeros and p=127 gives 255 ones.
- `start` outside IDLE is ignored.
- `pix_valid` outside GATHER is not accepted.
- A new `cfg_groups` value is not seen until the next accepted `start`.

## Timing
- **Reset values:**
  - state IDLE, `pix_cnt=0`, `grp_idx=0`.
  - `busy`, `done`, `pix_ready`, `out_valid`, `out_last` all 0.
  - `out_data` all zeros; `win` cleared.
- **Latency:** the last pixel is accepted in cycle N, then the FSM spends cycle N+1 in CONVERT. `out_valid` rises at cycle N+2.
- **Throughput:** with no stalls, one group every KERNEL_SIZE+2 cycles.
- **Frame end:** `done` pulses the cycle after the last handshake. `busy` drops the cycle after `done`. A `start` in the `done` cycle is ignored.
- **Handshake:** `out_valid` never drops without `out_ready`. `pix_ready` depends only on state, never on `pix_valid`.
- **Reset mid-frame:** immediate return to reset values. A partial window is discarded with no `done` and no output.
- **Wrap:** `cfg_groups` up to 2^GRP_W-1 is legal. `grp_idx` never wraps within a frame.

## Structure
- Package `bnn_bin_pkg` holds:
  - the `bin_ctrl_state_e` enum for the five states;
  - the pixel offset constant 128;
  - typedefs `pix_t` (signed BIT_WIDTH) and `lane_t` (CHANNEL_CNT bits).
- One sub-module: an instance of the existing `binarization_input`, fed from `win`, whose output is registered in CONVERT.
- The controller owns the FSM, the window registers, the counters and the output register only.

## Test plan
- `cfg_groups=1`, pixels 0,1,…,8 streamed back-to-back, `out_ready=1`:
  - `out_valid` appears 2 cycles after the 9th pixel;
  - lane0 has 128 ones and lane8 has 136 ones;
  - `out_last=1`, then one `done` pulse.
- Extremes:
  - pixels alternating -128/127 → lanes alternate all-zero / 255 ones (MSB 0).
- `cfg_groups=3` with `out_ready` held low 5 cycles per group:
  - `out_data` is stable while stalled;
  - `grp_idx` takes 0,1,2;
  - `out_last` is high only on group 2;
  - exactly 27 pixels are accepted.
- `cfg_groups=0` with `start`:
  - `done` the next cycle;
  - `pix_ready` never asserts.
- `pix_valid` toggled randomly, plus `start` pulses mid-frame:
  - window contents correct;
  - extra `start` pulses have no effect.
- `rst` asserted after 4 of 9 pixels:
  - all outputs return to 0 asynchronously;
  - a following frame with 9 pixels of value 5 gives 133 ones per lane.
